// File: rtl/mac_dot_if.sv
// mac_dot operand/result bundle: beat-qualified operands in, saturated
// result with its valid pulse, saturation flag and busy indication out.
interface mac_dot_if #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned OUT_WIDTH  = 8
);
   logic                  in_valid;
   logic                  mode;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic [DATA_WIDTH-1:0] c;
   logic [OUT_WIDTH-1:0]  out;
   logic                  out_valid;
   logic                  sat;
   logic                  busy;

   // Operand source side
   modport master (
      output in_valid, mode, a, b, c,
      input  out, out_valid, sat, busy
   );

   // MAC engine side
   modport slave (
      input  in_valid, mode, a, b, c,
      output out, out_valid, sat, busy
   );
endinterface

// File: rtl/mac_dot.sv
// mac_dot: pipelined multiply-accumulate engine. A beat is either a single
// a*b+c (mode 0) or one term of a DOT_LEN-term dot product with bias taken
// from the first term (mode 1). Accumulation is full precision; the result
// is clamped to OUT_WIDTH and flagged through sat.
//
// Pipeline: operands -> [stage 1: product] -> [stage 2: accumulate]
//           -> [output: saturate]; a beat sampled at edge k is reported
//           at edge k+2.
module mac_dot #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned DOT_LEN    = 4,
   parameter int unsigned SIGNED     = 0
) (
   input  logic      clk,
   input  logic      reset,
   mac_dot_if.slave  bus
);

   localparam int unsigned PROD_W = 2 * DATA_WIDTH;
   localparam int unsigned ACC_W  = PROD_W + $clog2(DOT_LEN) + 1;
   localparam int unsigned CNT_W  = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
   // Wide enough that clamp comparisons against OUT_WIDTH limits are exact
   localparam int unsigned SAT_W  = ACC_W + OUT_WIDTH;
   localparam logic        SGN    = (SIGNED != 0);

   // ---------------------------------------------------------------
   // Stage 1: product
   // ---------------------------------------------------------------
   logic [PROD_W-1:0]     a_ext;
   logic [PROD_W-1:0]     b_ext;
   logic [PROD_W-1:0]     prod;

   logic                  v1;
   logic                  m1;
   logic [PROD_W-1:0]     p1;
   logic [DATA_WIDTH-1:0] c1;

   // Extend operands to product width; low PROD_W bits of the extended
   // unsigned product equal the signed product when SIGNED is set.
   always_comb begin
      a_ext = {{DATA_WIDTH{SGN & bus.a[DATA_WIDTH-1]}}, bus.a};
      b_ext = {{DATA_WIDTH{SGN & bus.b[DATA_WIDTH-1]}}, bus.b};
      prod  = a_ext * b_ext;
   end

   // Stage-1 register: capture product, addend and mode of a valid beat
   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
         m1 <= 1'b0;
         p1 <= '0;
         c1 <= '0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            m1 <= bus.mode;
            p1 <= prod;
            c1 <= bus.c;
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: accumulate
   // ---------------------------------------------------------------
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic [ACC_W-1:0] acc_n;
   logic [CNT_W-1:0] cnt_n;
   logic [ACC_W-1:0] p_ext;
   logic [ACC_W-1:0] c_ext;
   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] sum;
   logic             last_term;
   logic             fire;

   logic             fin_v;
   logic [ACC_W-1:0] fin_q;

   // Next accumulator/count and result-complete decision for the stage-1 beat
   always_comb begin
      p_ext     = {{(ACC_W - PROD_W){SGN & p1[PROD_W-1]}}, p1};
      c_ext     = {{(ACC_W - DATA_WIDTH){SGN & c1[DATA_WIDTH-1]}}, c1};
      // Bias only enters on the first term; a mode 0 beat always uses its own c
      base      = (m1 && (count != '0)) ? acc : c_ext;
      sum       = base + p_ext;
      last_term = (count == CNT_W'(DOT_LEN - 1));
      acc_n     = acc;
      cnt_n     = count;
      fire      = 1'b0;
      if (v1) begin
         if (!m1 || last_term) begin
            // Result complete; a mode 0 beat also drops any partial frame
            fire  = 1'b1;
            acc_n = '0;
            cnt_n = '0;
         end else begin
            acc_n = sum;
            cnt_n = count + CNT_W'(1);
         end
      end
   end

   // Stage-2 register: accumulator, term count and unsaturated final result
   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= '0;
         count <= '0;
         fin_v <= 1'b0;
         fin_q <= '0;
      end else begin
         acc   <= acc_n;
         count <= cnt_n;
         fin_v <= fire;
         if (fire) begin
            fin_q <= sum;
         end
      end
   end

   // ---------------------------------------------------------------
   // Output stage: saturate
   // ---------------------------------------------------------------
   logic [SAT_W-1:0]     wide;
   logic [SAT_W-1:0]     umax;
   logic [SAT_W-1:0]     smax;
   logic [SAT_W-1:0]     smin;
   logic [OUT_WIDTH-1:0] res;
   logic                 clamp;

   logic [OUT_WIDTH-1:0] out_q;
   logic                 out_valid_q;
   logic                 sat_q;

   // Clamp the full-precision result into the OUT_WIDTH range
   always_comb begin
      wide = {{OUT_WIDTH{SGN & fin_q[ACC_W-1]}}, fin_q};
      umax = '0;
      umax[OUT_WIDTH-1:0] = '1;
      smax = '0;
      smax[OUT_WIDTH-2:0] = '1;
      smin = '1;
      smin[OUT_WIDTH-2:0] = '0;
      res   = wide[OUT_WIDTH-1:0];
      clamp = 1'b0;
      if (SGN) begin
         if ($signed(wide) > $signed(smax)) begin
            res   = smax[OUT_WIDTH-1:0];
            clamp = 1'b1;
         end else if ($signed(wide) < $signed(smin)) begin
            res   = smin[OUT_WIDTH-1:0];
            clamp = 1'b1;
         end
      end else begin
         if (wide > umax) begin
            res   = umax[OUT_WIDTH-1:0];
            clamp = 1'b1;
         end
      end
   end

   // Output register: result and sat hold until the next completed result
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= fin_v;
         if (fin_v) begin
            out_q <= res;
            sat_q <= clamp;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sat       = sat_q;
   assign bus.busy      = (count != '0) | v1;

endmodule

// File: doc/mac_dot.md
# mac_dot

Pipelined, parametrised multiply-accumulate engine; successor to the single-shot MAC. It performs either a one-beat `a*b + c` or a DOT_LEN-term dot product with bias, with a valid-qualified input stream, full-precision accumulation and saturating output. It sits in the datapath between operand sources and result consumers that accept one `out_valid` pulse per result.

## Interface
- DATA_WIDTH, 4: width of `a`, `b`, `c`.
- OUT_WIDTH, 8: width of `out`; must be ≥ DATA_WIDTH+1.
- DOT_LEN, 4: terms per dot-product frame; must be ≥ 1.
- SIGNED, 0: 0 = unsigned two's-complement-free arithmetic; 1 = all operands and `out` signed.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  beat qualifier; operands sampled only when high.
- mode  in  1  0 = single MAC, 1 = dot-product term; sampled with the beat.
- a  in  DATA_WIDTH  multiplicand.
- b  in  DATA_WIDTH  multiplier.
- c  in  DATA_WIDTH  addend (mode 0) / bias (mode 1, first term of frame only; ignored on other terms).
- out  out  OUT_WIDTH  result; holds last value between valid pulses.
- out_valid  out  1  one-cycle pulse per completed result.
- sat  out  1  result was clamped; valid with `out_valid`, holds with `out`.
- busy  out  1  high while a frame is partially accumulated or stage 1 holds a beat.

## Operation
- Stage 1 (register): product `p = a*b` at 2*DATA_WIDTH bits (sign-extended if SIGNED), `c` (extended), `mode`, valid bit.
- Stage 2 (accumulate/output), internal accumulator ACC_W = 2*DATA_WIDTH + clog2(DOT_LEN) + 1 bits; never overflows internally.
- Mode 0 beat: result = p + c; saturate to OUT_WIDTH; `out_valid` pulses.
- Mode 0 beat arriving while a frame is partial (count ≠ 0): partial frame is discarded (acc, count cleared, no output for it); the mode 0 beat is processed normally.
- Mode 1 beat, count = 0: acc = c + p. Count ≠ 0: acc = acc + p. Count increments.
- Mode 1 beat with count = DOT_LEN-1: result = final acc, saturated; `out_valid` pulses; acc and count clear. DOT_LEN = 1 degenerates to mode 0 behaviour.
- Saturation: unsigned clamps to 2^OUT_WIDTH-1; signed clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. `sat` = 1 iff clamped.
- `in_valid` low: no accumulator or count change; bubbles inside a frame are legal and unbounded.
- busy = (count ≠ 0) | stage-1 valid.

## Timing
- Reset values: out = 0, out_valid = 0, sat = 0, busy = 0; count, acc, stage-1 valid = 0.
- Reset asserted mid-frame: frame discarded, no output; next mode 1 beat starts a new frame.
- Latency: beat sampled at edge k → `out`/`out_valid`/`sat` updated at edge k+2 (visible cycle after k+2 edge... i.e. two clocks after sampling).
- Throughput: one beat per cycle, no backpressure; back-to-back frames and mixed modes at full rate.
- `out_valid` is high for exactly one cycle per result; `out`, `sat` hold until next result or reset.

## Test plan
(DATA_WIDTH=4, OUT_WIDTH=8, DOT_LEN=4, SIGNED=0 unless stated)
- Reset held 3 cycles with random inputs and in_valid=1 → out=0, out_valid=0, sat=0, busy=0 throughout.
- Mode 0 a=3 b=5 c=2 → 2 clocks later out=17, out_valid one cycle, sat=0.
- Mode 1 frame (1,2,c=10),(3,4),bubble×2,(5,6),(7,8) → single out_valid 2 clocks after 4th beat, out=110, sat=0; busy high from first beat until result.
- Mode 1 frame four beats a=b=15, c=1 on first → internal 901, out=255, sat=1.
- Two mode 1 beats (4,4),(4,4), then mode 0 a=2 b=2 c=0 → out=4 only; next full frame (1,1)×4 c=0 → out=4 (no leftover).
- SIGNED=1: mode 0 a=-8 b=7 c=-8 → out=-64, sat=0; mode 1 a=b=-8 ×4 → out=127, sat=1; reset after 2 terms then (1,1)×4 → out=4.
